// File: rtl/cpu_ifetch.sv
// Instruction fetch stage: issues the next PC on the instruction bus, returns
// the fetched word to p2, stalls the PC generator while a fetch is in flight,
// discards fetches on a p3 jump and turns bus timeouts into a fault word.
//
// state | meaning
// IDLE  | no request outstanding, nothing held for p2
// WAIT  | request on the bus, waiting for imem_ack
// HOLD  | word (or fault word) held for p2 while downstream stalls
// FLUSH | request outstanding after a jump; returning data is discarded
module cpu_ifetch #(
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] FAULT_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] p1_pc,
  input  logic        p3_jump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] p2_instr,
  output logic        p2_valid,
  output logic        p2_pipeline_bubble,
  output logic        p2_fault,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, FLUSH} state_t;

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic        req_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic        hold_fault, hold_fault_nxt;
  logic [7:0]  tmo_cnt, tmo_nxt;
  logic        issue;
  logic        drop;
  logic        tmo_hit;

  // the counter value this cycle would reach if no ack arrives
  assign tmo_hit = ((tmo_cnt + 8'd1) == TMO_LIM);

  // next-state, bus control and p2 outputs
  always_comb begin
    state_nxt      = state;
    req_nxt        = imem_req;
    addr_nxt       = imem_addr;
    hold_instr_nxt = hold_instr;
    hold_fault_nxt = hold_fault;
    tmo_nxt        = tmo_cnt;
    issue          = 1'b0;
    drop           = 1'b0;
    p2_valid       = 1'b0;
    p2_instr       = hold_instr;
    p2_fault       = 1'b0;

    case (state)
      IDLE: begin
        // a late ack arriving here belongs to an abandoned request
        if (!stall) issue = 1'b1;
      end
      WAIT: begin
        p2_valid = imem_ack;
        if (imem_ack) begin
          p2_instr = imem_rdata;
          tmo_nxt  = 8'd0;
          if (p3_jump) begin
            drop      = 1'b1;
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end else if (stall) begin
            hold_instr_nxt = imem_rdata;
            hold_fault_nxt = 1'b0;
            req_nxt        = 1'b0;
            state_nxt      = HOLD;
          end else begin
            issue = 1'b1;
          end
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
          if (tmo_hit) begin
            // a jump on the timeout cycle just abandons the request
            req_nxt = 1'b0;
            if (p3_jump) begin
              state_nxt = IDLE;
            end else begin
              hold_instr_nxt = FAULT_INSTR;
              hold_fault_nxt = 1'b1;
              state_nxt      = HOLD;
            end
          end else if (p3_jump) begin
            state_nxt = FLUSH;
          end
        end
      end
      HOLD: begin
        p2_valid = 1'b1;
        p2_fault = hold_fault;
        if (p3_jump) begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end else if (!stall) begin
          issue = 1'b1;
        end
      end
      FLUSH: begin
        // keep the bus request up so the slave can complete, then discard
        if (imem_ack) begin
          drop      = 1'b1;
          req_nxt   = 1'b0;
          tmo_nxt   = 8'd0;
          state_nxt = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
          if (tmo_hit) begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (issue) begin
      state_nxt = WAIT;
      req_nxt   = 1'b1;
      addr_nxt  = {p1_pc[31:2], 2'b00};
      tmo_nxt   = 8'd0;
    end
  end

  assign p2_pipeline_bubble = !p2_valid;

  // state and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= 32'h0;
      hold_instr  <= 32'h0;
      hold_fault  <= 1'b0;
      tmo_cnt     <= 8'd0;
      flush_count <= 16'h0;
    end else begin
      state      <= state_nxt;
      imem_req   <= req_nxt;
      imem_addr  <= addr_nxt;
      hold_instr <= hold_instr_nxt;
      hold_fault <= hold_fault_nxt;
      tmo_cnt    <= tmo_nxt;
      if (drop && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Bench for cpu_ifetch: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model of the fetch stage.
module tb_cpu_ifetch;

  localparam int          TMO   = 4;
  localparam logic [31:0] FAULT = 32'hDEAD_0F17;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic [31:0] p1_pc;
  logic        p3_jump;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] p2_instr;
  logic        p2_valid;
  logic        p2_pipeline_bubble;
  logic        p2_fault;
  logic [15:0] flush_count;

  int total = 0;
  int bad   = 0;

  cpu_ifetch #(.TIMEOUT(TMO), .FAULT_INSTR(FAULT)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .stall              (stall),
    .p1_pc              (p1_pc),
    .p3_jump            (p3_jump),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ack           (imem_ack),
    .imem_rdata         (imem_rdata),
    .p2_instr           (p2_instr),
    .p2_valid           (p2_valid),
    .p2_pipeline_bubble (p2_pipeline_bubble),
    .p2_fault           (p2_fault),
    .flush_count        (flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // model: a fetch is either outstanding (possibly doomed by a jump), or a
  // word is parked for p2, or neither
  bit          m_known   = 0;
  bit          m_pending = 0;
  bit          m_doomed  = 0;
  bit          m_parked  = 0;
  logic [31:0] m_word    = 0;
  bit          m_wfault  = 0;
  int          m_waited  = 0;
  logic [31:0] m_addr    = 0;
  int          m_drops   = 0;

  function automatic bit exp_valid();
    return m_parked || (m_pending && !m_doomed && imem_ack);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    bit v;
    v = exp_valid();
    chk("p2_valid", 32'(p2_valid), 32'(v));
    chk("bubble", 32'(p2_pipeline_bubble), 32'(!v));
    chk("imem_req", 32'(imem_req), 32'(m_pending));
    chk("imem_addr", imem_addr, m_addr);
    chk("p2_fault", 32'(p2_fault), 32'(m_parked && m_wfault));
    chk("flush_count", 32'(flush_count), 32'(m_drops > 65535 ? 65535 : m_drops));
    if (v) chk("p2_instr", p2_instr, m_parked ? m_word : imem_rdata);
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_update();
    bit v, taken, go, lost;
    if (!reset_n) begin
      m_known = 1; m_pending = 0; m_doomed = 0; m_parked = 0;
      m_word = 0; m_wfault = 0; m_waited = 0; m_addr = 0; m_drops = 0;
      return;
    end
    v     = exp_valid();
    taken = v && !stall && !p3_jump;
    go    = (!m_pending && !m_parked && !stall) || taken;
    lost  = (v && p3_jump) || (m_pending && m_doomed && imem_ack);
    if (m_pending && imem_ack) begin
      if (!m_doomed && !p3_jump && stall) begin
        m_parked = 1; m_word = imem_rdata; m_wfault = 0;
      end
      m_pending = 0; m_doomed = 0; m_waited = 0;
    end else if (m_pending) begin
      m_waited++;
      if (m_waited == TMO) begin
        if (!(m_doomed || p3_jump)) begin
          m_parked = 1; m_word = FAULT; m_wfault = 1;
        end
        m_pending = 0; m_doomed = 0;
      end else if (p3_jump) begin
        m_doomed = 1;
      end
    end else if (m_parked && (p3_jump || !stall)) begin
      m_parked = 0;
    end
    if (lost) m_drops++;
    if (go) begin
      m_pending = 1; m_doomed = 0; m_parked = 0; m_waited = 0;
      m_addr = {p1_pc[31:2], 2'b00};
    end
  endtask

  task automatic apply(input logic r, input logic s, input logic j, input logic a,
                       input logic [31:0] rd, input logic [31:0] pc);
    reset_n = r; stall = s; p3_jump = j; imem_ack = a; imem_rdata = rd; p1_pc = pc;
    @(negedge clock);
    if (m_known) model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic r, input logic s, input logic j, input logic a,
                     input logic [31:0] rd, input logic [31:0] pc);
    advance();
    apply(r, s, j, a, rd, pc);
  endtask

  initial begin
    logic r, s, j, a;
    int rst_left;

    // reset held three cycles
    apply(0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(p2_valid), 32'h0);
    chk("rst_instr", p2_instr, 32'h0);
    chk("rst_fault", 32'(p2_fault), 32'h0);
    chk("rst_flush", 32'(flush_count), 32'h0);

    // first fetch after release
    cyc(1, 0, 0, 0, 32'h0, 32'hFFFF_0000);
    cyc(1, 0, 0, 1, 32'h1111_1111, 32'h0000_1000);
    chk("first_addr", imem_addr, 32'hFFFF_0000);
    chk("first_valid", 32'(p2_valid), 32'h1);
    chk("first_instr", p2_instr, 32'h1111_1111);

    // back-to-back at 1-cycle latency
    cyc(1, 0, 0, 1, 32'hA0A0_0001, 32'h0000_1004);
    chk("b2b_addr0", imem_addr, 32'h0000_1000);
    chk("b2b_bubble0", 32'(p2_pipeline_bubble), 32'h0);
    cyc(1, 0, 0, 1, 32'hA0A0_0002, 32'h0000_1008);
    chk("b2b_addr1", imem_addr, 32'h0000_1004);
    chk("b2b_valid1", 32'(p2_valid), 32'h1);
    cyc(1, 0, 0, 1, 32'hA0A0_0003, 32'h0000_2000);
    chk("b2b_addr2", imem_addr, 32'h0000_1008);
    chk("b2b_bubble2", 32'(p2_pipeline_bubble), 32'h0);

    // ack delayed three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 32'h0, 32'h0000_2000);
      chk("dly_bubble", 32'(p2_pipeline_bubble), 32'h1);
      chk("dly_addr", imem_addr, 32'h0000_2000);
    end
    cyc(1, 0, 0, 1, 32'h2222_2222, 32'h0000_3000);
    chk("dly_valid", 32'(p2_valid), 32'h1);

    // stall on the ack cycle parks the word
    cyc(1, 1, 0, 1, 32'hDEAD_BEEF, 32'h0000_3000);
    chk("hold_addr", imem_addr, 32'h0000_3000);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 32'h0, 32'h0000_4000);
      chk("hold_instr", p2_instr, 32'hDEAD_BEEF);
      chk("hold_req", 32'(imem_req), 32'h0);
      chk("hold_valid", 32'(p2_valid), 32'h1);
    end
    cyc(1, 0, 0, 0, 32'h0, 32'h0000_4000);

    // jump while waiting, ack two cycles later is discarded
    cyc(1, 0, 1, 0, 32'h0, 32'h0000_8000);
    chk("jmp_req", 32'(imem_req), 32'h1);
    chk("jmp_addr", imem_addr, 32'h0000_4000);
    cyc(1, 0, 0, 0, 32'h0, 32'h0000_8000);
    cyc(1, 0, 0, 1, 32'h5555_5555, 32'h0000_8000);
    chk("jmp_valid", 32'(p2_valid), 32'h0);
    cyc(1, 0, 0, 0, 32'h0, 32'h0000_8000);
    chk("jmp_flush", 32'(flush_count), 32'h1);
    cyc(1, 0, 0, 0, 32'h0, 32'h0000_9000);
    chk("jmp_target", imem_addr, 32'h0000_8000);

    // timeout after TMO cycles without ack
    for (int i = 0; i < TMO - 1; i++) cyc(1, 0, 0, 0, 32'h0, 32'h0000_9000);
    cyc(1, 1, 0, 0, 32'h0, 32'h0000_9000);
    chk("tmo_req", 32'(imem_req), 32'h0);
    chk("tmo_valid", 32'(p2_valid), 32'h1);
    chk("tmo_fault", 32'(p2_fault), 32'h1);
    chk("tmo_instr", p2_instr, FAULT);
    cyc(1, 0, 0, 0, 32'h0, 32'h0000_A000);

    // reset mid-request, late ack ignored afterwards
    cyc(1, 0, 0, 0, 32'h0, 32'h0000_A000);
    cyc(0, 0, 0, 0, 32'h0, 32'h0000_A000);
    cyc(1, 1, 0, 1, 32'h7777_7777, 32'h0000_B000);
    chk("late_valid", 32'(p2_valid), 32'h0);
    chk("late_req", 32'(imem_req), 32'h0);
    cyc(1, 0, 0, 0, 32'h0, 32'h0000_B000);

    // randomized traffic
    rst_left = 0;
    for (int n = 0; n < 3000; n++) begin
      advance();
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(199, 0) == 0) rst_left = $urandom_range(2, 1);
      r = (rst_left == 0);
      s = ($urandom_range(3, 0) == 0);
      j = ($urandom_range(9, 0) == 0);
      a = m_pending && ($urandom_range(1, 0) == 1);
      apply(r, s, j, a, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
